// File: rtl/led_fx_pkg.sv
// led_fx_pkg: shared LED effect mode encodings and bounce direction constants
package led_fx_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_SHL,
    MODE_SHR,
    MODE_ROL,
    MODE_ROR,
    MODE_BOUNCE
  } mode_t;
  typedef enum logic {
    DIR_RIGHT,
    DIR_LEFT
  } dir_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler (clk, reset, en, clr, div in; step pulses when count reaches div while enabled)
module led_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             step
);
  logic [DIV_W-1:0] cnt;
  assign step = en && !clr && (cnt >= div);
  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en) cnt <= step ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/led_shift_engine.sv
// led_shift_engine: prescaled LED pattern shifter (en/mode/div/s_in/load/d_in in; q_out pattern, tick_out step pulse, wrap end pulse, dir bounce direction out)
module led_shift_engine
  import led_fx_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               DIV_W         = 24,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic             s_in,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out,
  output logic             tick_out,
  output logic             wrap,
  output logic             dir
);
  logic             step;
  logic             edge_hit;
  logic             wrap_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] rol;
  logic [WIDTH-1:0] ror;
  dir_t             dir_q;
  dir_t             dir_n;
  led_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .div  (div),
    .step (step)
  );
  assign rol      = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
  assign ror      = {q_out[0], q_out[WIDTH-1:1]};
  assign edge_hit = (dir_q == DIR_RIGHT) ? q_out[0] : q_out[WIDTH-1];
  assign dir      = dir_q;
  always_comb begin
    q_n    = q_out;
    dir_n  = dir_q;
    wrap_n = 1'b0;
    case (mode)
      MODE_SHL: q_n = {q_out[WIDTH-2:0], s_in};
      MODE_SHR: q_n = {s_in, q_out[WIDTH-1:1]};
      MODE_ROL: begin
        q_n    = rol;
        wrap_n = q_out[WIDTH-1];
      end
      MODE_ROR: begin
        q_n    = ror;
        wrap_n = q_out[0];
      end
      MODE_BOUNCE: begin
        wrap_n = edge_hit;
        dir_n  = edge_hit ? dir_t'(~dir_q) : dir_q;
        q_n    = (dir_n == DIR_RIGHT) ? ror : rol;
      end
      default: q_n = q_out;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      q_out    <= RESET_PATTERN;
      dir_q    <= DIR_RIGHT;
      tick_out <= 1'b0;
      wrap     <= 1'b0;
    end else if (load) begin
      q_out    <= d_in;
      dir_q    <= DIR_RIGHT;
      tick_out <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick_out <= step;
      wrap     <= step && wrap_n;
      if (step) begin
        q_out <= q_n;
        dir_q <= dir_n;
      end
    end
  end
endmodule

// File: doc/led_shift_engine.md
LED_SHIFT_ENGINE -- requirements
Module: led_shift_engine

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, giving the pattern register width (minimum 2).
REQ-002 The block SHALL take parameter DIV_W, default 24, giving the prescaler counter width.
REQ-003 The block SHALL take parameter RESET_PATTERN, default MSB-only (8'h80 at WIDTH=8), giving the pattern loaded at reset.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high, with ports named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 en  input  1  run enable for the prescaler and stepping.
REQ-008 mode  input  3  shift mode select.
REQ-009 div  input  DIV_W  step period minus one, in clk cycles.
REQ-010 s_in  input  1  serial data for the SHL and SHR modes.
REQ-011 load  input  1  parallel load strobe.
REQ-012 d_in  input  WIDTH  parallel load data.
REQ-013 q_out  output  WIDTH  current pattern, driven directly from a register.
REQ-014 tick_out  output  1  one-cycle pulse on every step.
REQ-015 wrap  output  1  one-cycle pulse on an end event.
REQ-016 dir  output  1  bounce direction: 0 = RIGHT (toward the LSB), 1 = LEFT.

Function
REQ-017 Prescaler: when en=1, the counter SHALL increment each cycle. When counter >= div, a step SHALL occur and the counter SHALL clear to 0. With div=0 a step SHALL occur every cycle.
REQ-018 When en=0, the counter SHALL hold its value, no step SHALL occur, and q_out SHALL hold.
REQ-019 Modes, applied at a step only:
- 0 HOLD: no change.
- 1 SHL: {q[W-2:0], s_in}.
- 2 SHR: {s_in, q[W-1:1]}.
- 3 ROL: rotate left by one.
- 4 ROR: rotate right by one.
- 5 BOUNCE: see REQ-020.
- 6 and 7: treated as HOLD.
REQ-020 BOUNCE:
- With dir=RIGHT and q[0]=0: rotate right.
- With dir=RIGHT and q[0]=1: dir becomes LEFT and the pattern rotates left in the same step.
- With dir=LEFT, the same rules apply mirrored on q[W-1].
- An all-zero pattern SHALL remain all-zero.
REQ-021 wrap SHALL pulse with the step tick in exactly these cases:
- ROL/ROR, when the bit moved across the end is 1.
- BOUNCE, when dir reverses.
- SHL/SHR, never.
REQ-022 tick_out SHALL be registered and SHALL be high for exactly the cycle after each step, aligned with the updated q_out. wrap SHALL follow the same timing.
REQ-023 load=1 SHALL have priority over a step and over en. On load, q_out SHALL take d_in on the next edge, the counter SHALL clear, and dir SHALL become RIGHT. No tick_out or wrap pulse SHALL occur for a load.
REQ-024 A mode change SHALL take effect at the next step. The counter SHALL not reset on a mode change, and dir SHALL be retained.
REQ-025 Lowering div below the current count SHALL cause a step on the next enabled cycle.

Reset
REQ-026 On reset, the following SHALL hold on the next edge, with reset overriding load and en:
- q_out = RESET_PATTERN
- counter = 0
- dir = RIGHT
- tick_out = 0
- wrap = 0
REQ-027 Reset asserted mid-period SHALL discard the partial count. The first step after reset release SHALL occur div+1 enabled cycles later.

Structure
REQ-028 The following SHALL be defined in shared package led_fx_pkg and not in led_shift_engine:
- mode encodings MODE_HOLD..MODE_BOUNCE
- direction constants DIR_RIGHT and DIR_LEFT
REQ-029 The prescaler SHALL be a sub-module led_tick_gen with ports clk, reset, en, clr, div and step. led_shift_engine SHALL contain the pattern register and the direction FSM.

Verification
REQ-030 Reset with WIDTH=8 and default RESET_PATTERN -> q_out=8'h80, dir=0, tick_out=0, wrap=0.
REQ-031 mode=4, div=3, en=1 from 8'h80 -> one step every 4 cycles: 8'h40, 8'h20 ... 8'h01, then 8'h80 with wrap=1.
REQ-032 mode=5, div=0 from 8'h80 -> 8'h40 ... 8'h01, then 8'h02 with dir=1 and wrap=1; reaching 8'h80 again -> 8'h40 with dir=0 and wrap=1.
REQ-033 mode=2, s_in=1, div=0 from 8'h00 -> 8'h80, 8'hC0, 8'hE0 on three consecutive steps; wrap stays 0.
REQ-034 load=1 with d_in=8'h3C during a step cycle, and en=0 one cycle later -> q_out=8'h3C, no tick, counter=0; q_out holds while en=0.
REQ-035 Reset asserted mid-bounce with dir=1 and a counter of 2 -> on the next edge q_out=8'h80, dir=0, and the first step comes div+1 enabled cycles after release.
